// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI mode-0 target answering flash-style READ commands
//
// Oversamples the SPI pins on clk, decodes an 8-bit opcode and a 24-bit
// address (MSB first), then streams bytes fetched through a req/valid byte port.
// Optional feature macro: SPI_RESP_FAST_READ_EN (accepts opcode 8'h0B followed
// by 8 dummy clocks before data).
//
// Ports:
//   clk, n_rst           system clock (>= 8x f_sclk), synchronous active-low reset
//   f_sclk, f_cs, f_mosi SPI pins from the initiator (asynchronous to clk)
//   f_miso, f_miso_oe    SPI data to the initiator and its pad output enable
//   rd_req, rd_addr      one-cycle byte fetch request and its address
//   rd_data, rd_valid    fetched byte and its one-cycle qualifier
//   busy                 synchronized chip-select active
//   underrun             sticky: a data byte was needed before it was fetched

module spi_flash_responder #(
    parameter logic [7:0] READ_OPCODE = 8'h03,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        f_sclk,
    input  logic        f_cs,
    input  logic        f_mosi,
    output logic        f_miso,
    output logic        f_miso_oe,
    output logic        rd_req,
    output logic [23:0] rd_addr,
    input  logic [7:0]  rd_data,
    input  logic        rd_valid,
    output logic        busy,
    output logic        underrun
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_ADDRESS,
`ifdef SPI_RESP_FAST_READ_EN
        ST_DUMMY,
`endif
        ST_DATA,
        ST_IGNORE
    } state_t;

    // Synchronizers and edge-detect history
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  op_sr_q, op_sr_d;
    logic [23:0] addr_sr_q, addr_sr_d;
    logic [23:0] rd_addr_q, rd_addr_d;
    logic        rd_req_q, rd_req_d;
    logic        outst_q, outst_d;     // request issued, rd_valid not yet seen
    logic        pend_q, pend_d;       // fetched byte waiting to be shifted out
    logic [7:0]  buf_q, buf_d;
    logic [7:0]  tx_sr_q, tx_sr_d;
    logic        miso_q, miso_d;
    logic        underrun_q, underrun_d;
`ifdef SPI_RESP_FAST_READ_EN
    logic        fast_q, fast_d;
`endif

    logic [7:0]  opcode_next;
    logic [23:0] addr_next;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    assign opcode_next = {op_sr_q[6:0], mosi_s};
    assign addr_next   = {addr_sr_q[22:0], mosi_s};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_sr_d    = op_sr_q;
        addr_sr_d  = addr_sr_q;
        rd_addr_d  = rd_addr_q;
        rd_req_d   = 1'b0;
        outst_d    = outst_q;
        pend_d     = pend_q;
        buf_d      = buf_q;
        tx_sr_d    = tx_sr_q;
        miso_d     = miso_q;
        underrun_d = underrun_q;
`ifdef SPI_RESP_FAST_READ_EN
        fast_d     = fast_q;
`endif

        if (cs_s) begin
            // Deselected: abandon everything, including any fetch in flight.
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
            outst_d = 1'b0;
            pend_d  = 1'b0;
            miso_d  = 1'b0;
        end else if (cs_fall) begin
            // A new transaction; any sclk edge in this cycle is ignored.
            state_d    = ST_OPCODE;
            cnt_d      = 5'd0;
            outst_d    = 1'b0;
            pend_d     = 1'b0;
            miso_d     = 1'b0;
            underrun_d = 1'b0;
`ifdef SPI_RESP_FAST_READ_EN
            fast_d     = 1'b0;
`endif
        end else begin
            // Only a fetch we actually asked for is accepted.
            if (rd_valid && outst_q) begin
                buf_d   = rd_data;
                pend_d  = 1'b1;
                outst_d = 1'b0;
            end

            case (state_q)
                ST_OPCODE: begin
                    if (sclk_rise) begin
                        op_sr_d = opcode_next;
                        cnt_d   = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d = 5'd0;
                            if (opcode_next == READ_OPCODE) begin
                                state_d = ST_ADDRESS;
`ifdef SPI_RESP_FAST_READ_EN
                                fast_d  = 1'b0;
                            end else if (opcode_next == 8'h0B) begin
                                state_d = ST_ADDRESS;
                                fast_d  = 1'b1;
`endif
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDRESS: begin
                    miso_d = 1'b0;
                    if (sclk_rise) begin
                        addr_sr_d = addr_next;
                        cnt_d     = cnt_q + 5'd1;
                        if (cnt_q == 5'd23) begin
                            cnt_d     = 5'd0;
                            rd_addr_d = addr_next;
                            rd_req_d  = 1'b1;
                            outst_d   = 1'b1;
`ifdef SPI_RESP_FAST_READ_EN
                            state_d   = fast_q ? ST_DUMMY : ST_DATA;
`else
                            state_d   = ST_DATA;
`endif
                        end
                    end
                end
`ifdef SPI_RESP_FAST_READ_EN
                ST_DUMMY: begin
                    miso_d = 1'b0;
                    if (sclk_rise) begin
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d   = 5'd0;
                            state_d = ST_DATA;
                        end
                    end
                end
`endif
                ST_DATA: begin
                    if (sclk_fall) begin
                        if (cnt_q == 5'd0) begin
                            // First bit of a byte: take the fetched byte, or
                            // send zeros for the whole byte if it is missing.
                            if (pend_d) begin
                                miso_d  = buf_d[7];
                                tx_sr_d = {buf_d[6:0], 1'b0};
                                pend_d  = 1'b0;
                            end else begin
                                miso_d     = 1'b0;
                                tx_sr_d    = 8'h00;
                                underrun_d = 1'b1;
                            end
                        end else begin
                            miso_d  = tx_sr_q[7];
                            tx_sr_d = {tx_sr_q[6:0], 1'b0};
                        end
                    end
                    if (sclk_rise) begin
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d     = 5'd0;
                            rd_addr_d = rd_addr_q + 24'd1;
                            // Never stack a second request on an unanswered one.
                            if (!outst_d) begin
                                rd_req_d = 1'b1;
                                outst_d  = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    miso_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= 5'd0;
            op_sr_q     <= 8'h00;
            addr_sr_q   <= 24'h0;
            rd_addr_q   <= 24'h0;
            rd_req_q    <= 1'b0;
            outst_q     <= 1'b0;
            pend_q      <= 1'b0;
            buf_q       <= 8'h00;
            tx_sr_q     <= 8'h00;
            miso_q      <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef SPI_RESP_FAST_READ_EN
            fast_q      <= 1'b0;
`endif
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], f_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], f_cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], f_mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_sr_q     <= op_sr_d;
            addr_sr_q   <= addr_sr_d;
            rd_addr_q   <= rd_addr_d;
            rd_req_q    <= rd_req_d;
            outst_q     <= outst_d;
            pend_q      <= pend_d;
            buf_q       <= buf_d;
            tx_sr_q     <= tx_sr_d;
            miso_q      <= miso_d;
            underrun_q  <= underrun_d;
`ifdef SPI_RESP_FAST_READ_EN
            fast_q      <= fast_d;
`endif
        end
    end

`ifdef SPI_RESP_FAST_READ_EN
    assign f_miso_oe = (state_q == ST_DATA) || (state_q == ST_DUMMY);
`else
    assign f_miso_oe = (state_q == ST_DATA);
`endif
    assign f_miso   = miso_q & (state_q == ST_DATA);
    assign rd_req   = rd_req_q;
    assign rd_addr  = rd_addr_q;
    assign busy     = ~cs_s;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - directed self-checking bench for spi_flash_responder
module tb_spi_flash_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        f_sclk, f_cs, f_mosi;
    logic        f_miso, f_miso_oe;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        busy, underrun;

    int total = 0;
    int bad   = 0;
    int req_cnt = 0;
    logic [23:0] req_log[$];
    logic resp_en = 1'b1;
    logic oe_seen;
    logic [7:0] d0, d1, junk;

    spi_flash_responder dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .f_sclk    (f_sclk),
        .f_cs      (f_cs),
        .f_mosi    (f_mosi),
        .f_miso    (f_miso),
        .f_miso_oe (f_miso_oe),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Byte store model: byte at address a is a[7:0] + 8'h95 (so 000010 -> A5).
    initial begin
        logic [23:0] a;
        rd_data  = 8'h00;
        rd_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rd_req === 1'b1) begin
                req_cnt++;
                req_log.push_back(rd_addr);
                if (resp_en) begin
                    a = rd_addr;
                    @(posedge clk); #1;
                    rd_data  = a[7:0] + 8'h95;
                    rd_valid = 1'b1;
                    @(posedge clk); #1;
                    rd_valid = 1'b0;
                    rd_data  = 8'h00;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - n; i--) begin
            f_mosi = tx[i];
            tick(HALF);
            rx[i] = f_miso;
            oe_seen = oe_seen | f_miso_oe;
            f_sclk = 1'b1;
            tick(HALF);
            f_sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic cs_begin();
        req_cnt = 0;
        req_log.delete();
        oe_seen = 1'b0;
        f_cs = 1'b0;
        tick(4);
    endtask

    task automatic cs_end();
        f_sclk = 1'b0;
        tick(2);
        f_cs = 1'b1;
        tick(8);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [23:0] addr);
        logic [7:0] r;
        spi_byte(op, r);
        spi_byte(addr[23:16], r);
        spi_byte(addr[15:8], r);
        spi_byte(addr[7:0], r);
    endtask

    initial begin
        n_rst  = 1'b0;
        f_sclk = 1'b0;
        f_cs   = 1'b1;
        f_mosi = 1'b0;
        oe_seen = 1'b0;
        tick(3);
        chk("rst_oe", f_miso_oe, 0);
        chk("rst_miso", f_miso, 0);
        chk("rst_req", rd_req, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        n_rst = 1'b1;
        tick(4);

        // Plain read at 000010, two bytes
        cs_begin();
        chk("a_busy", busy, 1);
        send_cmd(8'h03, 24'h000010);
        chk("a_oe_low_in_addr", oe_seen, 0);
        oe_seen = 1'b0;
        spi_byte(8'h00, d0);
        spi_byte(8'h00, d1);
        chk("a_oe_in_data", oe_seen, 1);
        chk("a_byte0", d0, 8'hA5);
        chk("a_byte1", d1, 8'hA6);
        cs_end();
        chk("a_req_cnt", req_cnt, 3);
        chk("a_addr0", req_log[0], 24'h000010);
        chk("a_addr1", req_log[1], 24'h000011);
        chk("a_addr2", req_log[2], 24'h000012);
        chk("a_oe_after_cs", f_miso_oe, 0);
        chk("a_busy_after_cs", busy, 0);

        // Address wrap FFFFFF -> 000000
        cs_begin();
        send_cmd(8'h03, 24'hFFFFFF);
        spi_byte(8'h00, d0);
        spi_byte(8'h00, d1);
        cs_end();
        chk("w_byte0", d0, 8'h94);
        chk("w_byte1", d1, 8'h95);
        chk("w_req_cnt", req_cnt, 3);
        chk("w_addr0", req_log[0], 24'hFFFFFF);
        chk("w_addr1", req_log[1], 24'h000000);
        chk("w_addr2", req_log[2], 24'h000001);

        // Unknown opcode 9F -> ignored
        cs_begin();
        send_cmd(8'h9F, 24'h000010);
        spi_byte(8'h00, d0);
        chk("i_oe_never", oe_seen, 0);
        chk("i_miso", d0, 8'h00);
        cs_end();
        chk("i_req_cnt", req_cnt, 0);
        chk("i_busy_after_cs", busy, 0);

`ifdef SPI_RESP_FAST_READ_EN
        // Fast read: 0B + address + 8 dummy clocks, then data
        cs_begin();
        send_cmd(8'h0B, 24'h000020);
        oe_seen = 1'b0;
        spi_byte(8'hFF, junk);
        chk("f_dummy_oe", oe_seen, 1);
        chk("f_dummy_miso", junk, 8'h00);
        spi_byte(8'h00, d0);
        cs_end();
        chk("f_byte0", d0, 8'hB5);
        chk("f_req_cnt", req_cnt, 2);
        chk("f_addr0", req_log[0], 24'h000020);
`else
        // Without the fast-read feature 0B is just another unknown opcode
        cs_begin();
        send_cmd(8'h0B, 24'h000020);
        spi_byte(8'h00, d0);
        cs_end();
        chk("f_0b_oe_never", oe_seen, 0);
        chk("f_0b_req_cnt", req_cnt, 0);
`endif

        // Fetch withheld -> zeros and sticky underrun
        resp_en = 1'b0;
        cs_begin();
        send_cmd(8'h03, 24'h000010);
        spi_byte(8'h00, d0);
        chk("u_byte0", d0, 8'h00);
        chk("u_flag", underrun, 1);
        cs_end();
        chk("u_single_req", req_cnt, 1);
        chk("u_sticky", underrun, 1);
        resp_en = 1'b1;
        cs_begin();
        chk("u_cleared", underrun, 0);
        cs_end();

        // Abort after 12 address bits
        cs_begin();
        spi_byte(8'h03, junk);
        spi_byte(8'h00, junk);
        spi_bits(8'h00, 4, junk);
        cs_end();
        chk("x_req_cnt", req_cnt, 0);
        chk("x_oe", f_miso_oe, 0);
        cs_begin();
        send_cmd(8'h03, 24'h000011);
        spi_byte(8'h00, d0);
        cs_end();
        chk("x_next_read", d0, 8'hA6);

        // Reset in the middle of a data phase
        cs_begin();
        send_cmd(8'h03, 24'h000010);
        spi_byte(8'h00, d0);
        chk("r_pre_byte", d0, 8'hA5);
        n_rst = 1'b0;
        tick(1);
        n_rst = 1'b1;
        chk("r_oe", f_miso_oe, 0);
        chk("r_miso", f_miso, 0);
        chk("r_req", rd_req, 0);
        chk("r_addr", rd_addr, 0);
        chk("r_busy", busy, 0);
        chk("r_underrun", underrun, 0);
        cs_end();
        cs_begin();
        send_cmd(8'h03, 24'h000010);
        spi_byte(8'h00, d0);
        cs_end();
        chk("r_after_byte", d0, 8'hA5);
        chk("r_after_req", req_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
